mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_rr_priority4.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 93 +++++++++
 tb/tb_mem_bus_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory bus arbiter: bus widths, requester count and
// the controller state encoding.
package mem_bus_arbiter_pkg;

   localparam int ADDRESS_BUS_WIDTH = 32;
   localparam int DATA_BUS_WIDTH    = 32;
   localparam int NUM_REQ           = 4;
   localparam int SEL_W             = $clog2(NUM_REQ);
   localparam int CNT_W             = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_priority4.sv
// Combinational round-robin search over four requesters. The search starts at
// ptr, ascends and wraps from 3 back to 0.
module rr_priority4
   import mem_bus_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               valid,
   output logic [SEL_W-1:0]   winner
);

   logic [SEL_W-1:0] w_idx;

   // Walk from the farthest offset down to offset 0 so the nearest requester
   // at or after ptr overwrites any earlier candidate.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would infer a latch.
      valid  = 1'b0;
      winner = ptr;
      w_idx  = ptr;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         w_idx = ptr + SEL_W'(i);
         if (req[w_idx]) begin
            valid  = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared memory
// port; drives the select line of the external address/data muxes.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               mem_ready,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   select,
   output logic               mem_en,
   output logic [NUM_REQ-1:0] ack,
   output logic               err
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t             r_state;
   logic [SEL_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [NUM_REQ-1:0] r_grant;
   logic [SEL_W-1:0]   r_select;
   logic               r_mem_en;
   logic [NUM_REQ-1:0] r_ack;
   logic               r_err;

   logic               w_valid;
   logic [SEL_W-1:0]   w_winner;

   rr_priority4 u_rr (
      .req    (req),
      .ptr    (r_ptr),
      .valid  (w_valid),
      .winner (w_winner)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ptr    <= '0;
         r_count  <= '0;
         r_grant  <= '0;
         r_select <= '0;
         r_mem_en <= 1'b0;
         r_ack    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant  <= NUM_REQ'(1) << w_winner;
                  r_select <= w_winner;
                  r_mem_en <= 1'b1;
                  r_ptr    <= w_winner + SEL_W'(1);
                  r_count  <= '0;
                  r_state  <= ST_BUSY;
               end else begin
                  r_grant  <= '0;
                  r_mem_en <= 1'b0;
               end
            end
            ST_BUSY: begin
               // mem_ready outranks a timeout landing in the same cycle.
               if (mem_ready || (r_count == TO_LAST)) begin
                  r_ack    <= r_grant;
                  r_err    <= ~mem_ready;
                  r_grant  <= '0;
                  r_mem_en <= 1'b0;
                  r_count  <= '0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign grant  = r_grant;
   assign select = r_select;
   assign mem_en = r_mem_en;
   assign ack    = r_ack;
   assign err    = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed grant/ack sequences covering
// round-robin order, pointer wrap, timeout, ready-vs-timeout priority and reset.
module tb_mem_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       mem_ready;
   logic [3:0] grant;
   logic [1:0] select;
   logic       mem_en;
   logic [3:0] ack;
   logic       err;

   int n_vec  = 0;
   int n_miss = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .mem_ready (mem_ready),
      .grant     (grant),
      .select    (select),
      .mem_en    (mem_en),
      .ack       (ack),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then stable for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed as {grant, select, mem_en, ack, err}.
   task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic e, input logic [3:0] a, input logic er);
      check(tag, 32'({grant, select, mem_en, ack, err}), 32'({g, s, e, a, er}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; req = 4'b0000; mem_ready = 1'b0;
      tick();
      expect_out("reset_state", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

      // Single request, ready on third BUSY cycle
      reset = 1'b0; req = 4'b0001;
      tick(); expect_out("r030_grant", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      req = 4'b0000;
      tick(); expect_out("r030_busy1", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("r030_busy2", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      mem_ready = 1'b1;
      tick(); expect_out("r030_ack", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
      tick(); expect_out("idle_ready_ignored", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

      // Round robin with all requesting, pointer wrap from 3
      reset = 1'b1; mem_ready = 1'b0;
      tick(); reset = 1'b0;
      req = 4'b1111; mem_ready = 1'b1;
      tick(); expect_out("rr_g0", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("rr_a0", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
      tick(); expect_out("rr_g1", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("rr_a1", 4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0);
      tick(); expect_out("rr_g2", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
      req = 4'b0101;
      tick(); expect_out("rr_a2", 4'b0000, 2'd2, 1'b0, 4'b0100, 1'b0);
      tick(); expect_out("wrap_g0", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("wrap_a0", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
      tick(); expect_out("ptr1_g2", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
      req = 4'b1111;
      tick(); expect_out("ptr1_a2", 4'b0000, 2'd2, 1'b0, 4'b0100, 1'b0);
      tick(); expect_out("rr_g3", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("rr_a3", 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0);
      tick(); expect_out("rr_g0b", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);
      tick(); expect_out("rr_a0b", 4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0);
      req = 4'b0000; mem_ready = 1'b0;
      tick(); expect_out("rr_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

      // Timeout after 4 BUSY cycles (ptr=1 so requester 2 wins)
      req = 4'b0100;
      tick(); expect_out("to_grant", 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
      req = 4'b0000;
      for (int i = 1; i <= 3; i++) begin
         tick(); expect_out($sformatf("to_busy%0d", i), 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0);
      end
      tick(); expect_out("to_ack_err", 4'b0000, 2'd2, 1'b0, 4'b0100, 1'b1);
      tick(); expect_out("to_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);

      // Ready on the cycle the timeout would fire: normal ack (ptr=3)
      req = 4'b1000;
      tick(); expect_out("pri_grant", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
      req = 4'b0000;
      for (int i = 1; i <= 3; i++) begin
         tick(); expect_out($sformatf("pri_busy%0d", i), 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
      end
      mem_ready = 1'b1;
      tick(); expect_out("pri_ack_noerr", 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0);
      mem_ready = 1'b0;
      tick(); expect_out("pri_idle", 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0);

      // Granted bit dropped mid-BUSY, other bits raised (ptr=0)
      req = 4'b0010;
      tick(); expect_out("drop_grant", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
      req = 4'b1101;
      tick(); expect_out("drop_hold", 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
      mem_ready = 1'b1;
      tick(); expect_out("drop_ack", 4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0);
      req = 4'b0000; mem_ready = 1'b0;
      tick(); expect_out("drop_idle_sel_hold", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);

      // Reset during BUSY aborts silently and clears ptr (ptr=2)
      req = 4'b1000;
      tick(); expect_out("rst_grant", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0);
      reset = 1'b1; mem_ready = 1'b1;
      tick(); expect_out("rst_abort", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
      reset = 1'b0; mem_ready = 1'b0; req = 4'b1111;
      tick(); expect_out("rst_ptr0", 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
